// File: rtl/ct_spsram_512x59_arb_if.sv
// Request, read-return and SRAM-pin bundle for ct_spsram_512x59_arb.
// slave = arbiter side; master = requesters plus the SRAM macro wrapper.
interface ct_spsram_512x59_arb_if #(
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 59
);
   logic                  req0_vld;
   logic                  req0_wr;
   logic [ADDR_WIDTH-1:0] req0_addr;
   logic [DATA_WIDTH-1:0] req0_wdata;
   logic [DATA_WIDTH-1:0] req0_wmask;
   logic                  req0_gnt;

   logic                  req1_vld;
   logic                  req1_wr;
   logic [ADDR_WIDTH-1:0] req1_addr;
   logic [DATA_WIDTH-1:0] req1_wdata;
   logic [DATA_WIDTH-1:0] req1_wmask;
   logic                  req1_gnt;

   logic                  rdata_vld;
   logic                  rdata_id;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  init_busy;

   logic                  sram_cen;
   logic                  sram_gwen;
   logic [DATA_WIDTH-1:0] sram_wen;
   logic [ADDR_WIDTH-1:0] sram_a;
   logic [DATA_WIDTH-1:0] sram_d;
   logic [DATA_WIDTH-1:0] sram_q;

   modport slave (
      input  req0_vld, req0_wr, req0_addr, req0_wdata, req0_wmask,
      output req0_gnt,
      input  req1_vld, req1_wr, req1_addr, req1_wdata, req1_wmask,
      output req1_gnt,
      output rdata_vld, rdata_id, rdata, init_busy,
      output sram_cen, sram_gwen, sram_wen, sram_a, sram_d,
      input  sram_q
   );

   modport master (
      output req0_vld, req0_wr, req0_addr, req0_wdata, req0_wmask,
      input  req0_gnt,
      output req1_vld, req1_wr, req1_addr, req1_wdata, req1_wmask,
      input  req1_gnt,
      input  rdata_vld, rdata_id, rdata, init_busy,
      input  sram_cen, sram_gwen, sram_wen, sram_a, sram_d,
      output sram_q
   );
endinterface

// File: rtl/ct_spsram_512x59_arb.sv
// Round-robin two-requester arbiter/sequencer for a 512x59 single-port SRAM.
// Optional power-up clear sequence enabled by macro CT_SPSRAM_ARB_INIT_EN.
module ct_spsram_512x59_arb #(
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 59,
   parameter int INIT_DEPTH = 512
) (
   input  logic                  forever_cpuclk,
   input  logic                  cpurst_b,
   ct_spsram_512x59_arb_if.slave bus
);
   logic                  run;
   logic                  init_act;
   logic [ADDR_WIDTH-1:0] init_addr;
   logic                  gnt0;
   logic                  gnt1;
   logic                  gnt_any;
   logic                  acc_wr;
   logic [ADDR_WIDTH-1:0] acc_addr;
   logic [DATA_WIDTH-1:0] acc_wdata;
   logic [DATA_WIDTH-1:0] acc_wmask;
   logic                  rr_ptr_q, rr_ptr_d;
   logic                  rd_pend_q, rd_pend_d;
   logic                  rd_id_q, rd_id_d;
   logic [DATA_WIDTH-1:0] hold_q, hold_d;
   logic [ADDR_WIDTH-1:0] sram_a_q, sram_a_d;
   logic [DATA_WIDTH-1:0] sram_d_q, sram_d_d;

   if (INIT_DEPTH < 1 || INIT_DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_init_depth
      $error("INIT_DEPTH must lie in 1 .. 2**ADDR_WIDTH");
   end

`ifdef CT_SPSRAM_ARB_INIT_EN
   typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;
   localparam logic [ADDR_WIDTH-1:0] INIT_LAST = ADDR_WIDTH'(INIT_DEPTH - 1);

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;

   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         state_q    <= ST_INIT;
         init_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
      end
   end

   // Gating with cpurst_b keeps the SRAM idle while reset is held low.
   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      init_act   = 1'b0;
      run        = 1'b0;
      case (state_q)
         ST_INIT: begin
            init_act   = cpurst_b;
            init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
            if (init_cnt_q == INIT_LAST) state_d = ST_RUN;
         end
         default: run = cpurst_b;
      endcase
   end

   assign init_addr = init_cnt_q;
`else
   assign run       = cpurst_b;
   assign init_act  = 1'b0;
   assign init_addr = '0;
`endif

   // rr_ptr names the requester that wins the next tie.
   always_comb begin
      gnt0      = run & bus.req0_vld & (~bus.req1_vld | ~rr_ptr_q);
      gnt1      = run & bus.req1_vld & (~bus.req0_vld |  rr_ptr_q);
      gnt_any   = gnt0 | gnt1;
      acc_wr    = gnt1 ? bus.req1_wr    : bus.req0_wr;
      acc_addr  = gnt1 ? bus.req1_addr  : bus.req0_addr;
      acc_wdata = gnt1 ? bus.req1_wdata : bus.req0_wdata;
      acc_wmask = gnt1 ? bus.req1_wmask : bus.req0_wmask;

      rr_ptr_d = rr_ptr_q;
      if (gnt0)      rr_ptr_d = 1'b1;
      else if (gnt1) rr_ptr_d = 1'b0;

      rd_pend_d = gnt_any & ~acc_wr;
      rd_id_d   = rd_pend_d ? gnt1 : rd_id_q;
      hold_d    = rd_pend_q ? bus.sram_q : hold_q;
   end

   // Address and data pins hold their last value when idle to avoid toggling.
   always_comb begin
      bus.sram_cen  = 1'b1;
      bus.sram_gwen = 1'b1;
      bus.sram_wen  = '1;
      sram_a_d      = sram_a_q;
      sram_d_d      = sram_d_q;
      if (init_act) begin
         bus.sram_cen  = 1'b0;
         bus.sram_gwen = 1'b0;
         bus.sram_wen  = '0;
         sram_a_d      = init_addr;
         sram_d_d      = '0;
      end else if (gnt_any) begin
         bus.sram_cen  = 1'b0;
         bus.sram_gwen = ~acc_wr;
         bus.sram_wen  = acc_wr ? ~acc_wmask : '1;
         sram_a_d      = acc_addr;
         sram_d_d      = acc_wr ? acc_wdata : sram_d_q;
      end
   end

   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         rr_ptr_q  <= 1'b0;
         rd_pend_q <= 1'b0;
         rd_id_q   <= 1'b0;
         hold_q    <= '0;
      end else begin
         rr_ptr_q  <= rr_ptr_d;
         rd_pend_q <= rd_pend_d;
         rd_id_q   <= rd_id_d;
         hold_q    <= hold_d;
      end
   end

   always_ff @(posedge forever_cpuclk) begin
      sram_a_q <= sram_a_d;
      sram_d_q <= sram_d_d;
   end

   assign bus.req0_gnt  = gnt0;
   assign bus.req1_gnt  = gnt1;
   assign bus.sram_a    = sram_a_d;
   assign bus.sram_d    = sram_d_d;
   assign bus.init_busy = init_act;
   assign bus.rdata_vld = rd_pend_q;
   assign bus.rdata_id  = rd_id_q;
   assign bus.rdata     = rd_pend_q ? bus.sram_q : hold_q;
endmodule

// File: tb/tb_ct_spsram_512x59_arb.sv
// Directed and randomized bench for ct_spsram_512x59_arb with an SRAM model
// and a memory/fairness reference model; honours CT_SPSRAM_ARB_INIT_EN.
module tb_ct_spsram_512x59_arb;
   localparam int AW = 9;
   localparam int DW = 59;
   localparam int DEPTH = 512;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   ct_spsram_512x59_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   ct_spsram_512x59_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_DEPTH(DEPTH)) dut (
      .forever_cpuclk(clk),
      .cpurst_b      (rst_n),
      .bus           (bus)
   );

   logic          q_vld  [2];
   logic          q_wr   [2];
   logic [AW-1:0] q_addr [2];
   logic [DW-1:0] q_data [2];
   logic [DW-1:0] q_mask [2];

   assign bus.req0_vld   = q_vld[0];
   assign bus.req0_wr    = q_wr[0];
   assign bus.req0_addr  = q_addr[0];
   assign bus.req0_wdata = q_data[0];
   assign bus.req0_wmask = q_mask[0];
   assign bus.req1_vld   = q_vld[1];
   assign bus.req1_wr    = q_wr[1];
   assign bus.req1_addr  = q_addr[1];
   assign bus.req1_wdata = q_data[1];
   assign bus.req1_wmask = q_mask[1];

   function automatic logic [DW-1:0] pat(input int i);
      logic [63:0] x;
      x = 64'h9E3779B97F4A7C15 * 64'(i + 1);
      return x[DW-1:0];
   endfunction

   // SRAM macro model: active-low pins, one-cycle read latency.
   logic          fill_req = 1'b0;
   logic [DW-1:0] sram_mem [DEPTH];
   always @(posedge clk) begin
      if (fill_req) begin
         for (int i = 0; i < DEPTH; i++) sram_mem[i] <= pat(i);
      end else if (!bus.sram_cen) begin
         if (!bus.sram_gwen)
            sram_mem[bus.sram_a] <= (sram_mem[bus.sram_a] & bus.sram_wen) | (bus.sram_d & ~bus.sram_wen);
         else
            bus.sram_q <= sram_mem[bus.sram_a];
      end
   end

   logic [DW-1:0] exp_mem [DEPTH];
   logic          last_served;
   logic          exp_rid;
   logic [DW-1:0] exp_hold;
   logic          exp_g0, exp_g1;
   int            n_tests = 0;
   int            n_fail  = 0;
   int            vld_seen = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      last_served = 1'b1;
      exp_rid     = 1'b0;
      exp_hold    = '0;
   endtask

   task automatic set_req(input int r, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [DW-1:0] m);
      q_vld[r] = 1'b1; q_wr[r] = wr; q_addr[r] = a; q_data[r] = d; q_mask[r] = m;
   endtask

   // One clock: grant/pin check before the edge, read-return check after it.
   task automatic step(output logic og0, output logic og1);
      logic          e0, e1, ewr, nrd;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed, em, nd, ewen;
      int            r;
      @(negedge clk);
      if (q_vld[0] && q_vld[1]) begin
         e0 = last_served;
         e1 = !last_served;
      end else begin
         e0 = q_vld[0];
         e1 = q_vld[1];
      end
      og0 = bus.req0_gnt;
      og1 = bus.req1_gnt;
      chk("gnt0", 64'(og0), 64'(e0));
      chk("gnt1", 64'(og1), 64'(e1));
      chk("init_busy", 64'(bus.init_busy), 64'(0));
      chk("sram_cen", 64'(bus.sram_cen), 64'(!(e0 || e1)));
      nrd = 1'b0;
      nd  = '0;
      if (e0 || e1) begin
         r    = e1 ? 1 : 0;
         ewr  = q_wr[r]; ea = q_addr[r]; ed = q_data[r]; em = q_mask[r];
         ewen = ewr ? ~em : '1;
         chk("sram_a", 64'(bus.sram_a), 64'(ea));
         chk("sram_gwen", 64'(bus.sram_gwen), 64'(!ewr));
         chk("sram_wen", 64'(bus.sram_wen), 64'(ewen));
         if (ewr) begin
            chk("sram_d", 64'(bus.sram_d), 64'(ed));
            exp_mem[ea] = (exp_mem[ea] & ~em) | (ed & em);
         end else begin
            nrd     = 1'b1;
            nd      = exp_mem[ea];
            exp_rid = e1;
         end
         last_served = e1;
      end else begin
         ewen = '1;
         chk("idle_gwen", 64'(bus.sram_gwen), 64'(1));
         chk("idle_wen", 64'(bus.sram_wen), 64'(ewen));
      end
      @(posedge clk);
      #1;
      if (nrd) exp_hold = nd;
      chk("rdata_vld", 64'(bus.rdata_vld), 64'(nrd));
      chk("rdata_id", 64'(bus.rdata_id), 64'(exp_rid));
      chk("rdata", 64'(bus.rdata), 64'(exp_hold));
      if (bus.rdata_vld === 1'b1) vld_seen++;
      exp_g0 = e0;
      exp_g1 = e1;
   endtask

   task automatic release_reset();
`ifdef CT_SPSRAM_ARB_INIT_EN
      int busy;
`endif
      @(posedge clk);
      #1;
      rst_n = 1'b1;
`ifdef CT_SPSRAM_ARB_INIT_EN
      #1;
      busy = 0;
      while (bus.init_busy === 1'b1 && busy < 1000) begin
         chk("init_gnt", 64'({bus.req0_gnt, bus.req1_gnt}), 64'(0));
         chk("init_cen", 64'({bus.sram_cen, bus.sram_gwen}), 64'(0));
         chk("init_wen", 64'(bus.sram_wen), 64'(0));
         chk("init_a", 64'(bus.sram_a), 64'(busy));
         busy++;
         @(posedge clk);
         #1;
      end
      chk("init_len", 64'(busy), 64'(DEPTH));
      for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
`endif
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog");
   end

   initial begin
      logic          og0, og1;
      logic [5:0]    h0, h1;
      logic [63:0]   rnd;
      logic [DW-1:0] rd, rm;

      for (int r = 0; r < 2; r++) begin
         q_vld[r] = 1'b0; q_wr[r] = 1'b0; q_addr[r] = '0; q_data[r] = '0; q_mask[r] = '0;
      end
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      q_vld[0] = 1'b1;
      q_vld[1] = 1'b1;
      #2;
      chk("rst_gnt0", 64'(bus.req0_gnt), 64'(0));
      chk("rst_gnt1", 64'(bus.req1_gnt), 64'(0));
      chk("rst_cen", 64'(bus.sram_cen), 64'(1));
      chk("rst_rvld", 64'(bus.rdata_vld), 64'(0));
      chk("rst_rid", 64'(bus.rdata_id), 64'(0));
      chk("rst_rdata", 64'(bus.rdata), 64'(0));
      chk("rst_busy", 64'(bus.init_busy), 64'(0));
      q_vld[0] = 1'b0;
      q_vld[1] = 1'b0;
      @(posedge clk); #1 fill_req = 1'b1;
      @(posedge clk); #1 fill_req = 1'b0;
      for (int i = 0; i < DEPTH; i++) exp_mem[i] = pat(i);
      model_reset();
`ifdef CT_SPSRAM_ARB_INIT_EN
      set_req(0, 1'b0, 9'h1FF, '0, '0);
      release_reset();
      step(og0, og1);
      q_vld[0] = 1'b0;
      chk("init_first_gnt", 64'(og0), 64'(1));
      chk("init_rdata", 64'(bus.rdata), 64'(0));
`else
      release_reset();
`endif

      // Full write by req0, read back by req1.
      set_req(0, 1'b1, 9'h1A5, 59'h5A5A5A5A5A5A5A5, '1);
      step(og0, og1); q_vld[0] = 1'b0;
      set_req(1, 1'b0, 9'h1A5, '0, '0);
      step(og0, og1); q_vld[1] = 1'b0;
      chk("t1_vld", 64'(bus.rdata_vld), 64'(1));
      chk("t1_id", 64'(bus.rdata_id), 64'(1));
      chk("t1_rdata", 64'(bus.rdata), 64'(59'h5A5A5A5A5A5A5A5));

      // Partial-mask write.
      set_req(0, 1'b1, 9'd3, '1, '1);
      step(og0, og1);
      set_req(0, 1'b1, 9'd3, '0, 59'hF);
      step(og0, og1);
      set_req(0, 1'b0, 9'd3, '0, '0);
      step(og0, og1); q_vld[0] = 1'b0;
      chk("t2_rdata", 64'(bus.rdata), 64'(59'h7FFFFFFFFFFFFF0));

      // Hold: one read, four idle cycles, then a write to the same address.
      vld_seen = 0;
      set_req(0, 1'b0, 9'd3, '0, '0);
      step(og0, og1); q_vld[0] = 1'b0;
      for (int i = 0; i < 4; i++) step(og0, og1);
      set_req(0, 1'b1, 9'd3, '0, '1);
      step(og0, og1); q_vld[0] = 1'b0;
      chk("hold_pulses", 64'(vld_seen), 64'(1));
      chk("hold_rdata", 64'(bus.rdata), 64'(59'h7FFFFFFFFFFFFF0));

      // Reset while a read return is on the outputs.
      set_req(1, 1'b1, 9'd5, 59'h123456789ABCDEF, '1);
      step(og0, og1); q_vld[1] = 1'b0;
      set_req(0, 1'b0, 9'd5, '0, '0);
      step(og0, og1); q_vld[0] = 1'b0;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("midrst_rvld", 64'(bus.rdata_vld), 64'(0));
      chk("midrst_rdata", 64'(bus.rdata), 64'(0));
      release_reset();
      vld_seen = 0;
      step(og0, og1);
      chk("midrst_noret", 64'(vld_seen), 64'(0));

      // Contention: both requesters valid every cycle.
      h0 = '0;
      h1 = '0;
      set_req(0, 1'b0, 9'd10, '0, '0);
      set_req(1, 1'b0, 9'd11, '0, '0);
      for (int i = 0; i < 6; i++) begin
         step(og0, og1);
         h0[i] = og0;
         h1[i] = og1;
      end
      q_vld[0] = 1'b0;
      q_vld[1] = 1'b0;
      chk("contend_g0", 64'(h0), 64'(6'b010101));
      chk("contend_g1", 64'(h1), 64'(6'b101010));
      chk("contend_both", 64'(h0 & h1), 64'(0));

      // Random traffic on a small address window.
      for (int s = 0; s < 300; s++) begin
         for (int r = 0; r < 2; r++) begin
            if (!q_vld[r] && $urandom_range(0, 99) < 60) begin
               rnd = {$urandom, $urandom};
               rd  = rnd[DW-1:0];
               rnd = {$urandom, $urandom};
               case ($urandom_range(0, 3))
                  0:       rm = '0;
                  1:       rm = '1;
                  default: rm = rnd[DW-1:0];
               endcase
               set_req(r, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), rd, rm);
            end
         end
         step(og0, og1);
         if (exp_g0) q_vld[0] = 1'b0;
         if (exp_g1) q_vld[1] = 1'b0;
      end
      q_vld[0] = 1'b0;
      q_vld[1] = 1'b0;
      step(og0, og1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/ct_spsram_512x59_arb.md
Name: ct_spsram_512x59_arb

Overview:
- Two-requester arbiter and sequencer in front of one 512x59 single-port SRAM.
- Active-low SRAM macro pins: CEN, GWEN, per-bit WEN.
- Converts two active-high valid/grant request channels into at most one SRAM access per cycle, with fair round-robin sharing.
- Returns read data with a fixed one-cycle latency and a requester tag, and holds the last read data stable.
- Sits between a cache/BHT-style array owner (e.g. lookup and refill pipes) and the SRAM macro wrapper.

Parameters:
- ADDR_WIDTH, 9, SRAM address width (512 entries).
- DATA_WIDTH, 59, data and bit-mask width.
- INIT_DEPTH, 512, number of entries cleared by the optional init sequence.

Ports:
- forever_cpuclk  in  1  clock.
- cpurst_b  in  1  asynchronous active-low reset.
- req0_vld  in  1  requester 0 access request.
- req0_wr  in  1  1 = write, 0 = read.
- req0_addr  in  9  address.
- req0_wdata  in  59  write data.
- req0_wmask  in  59  active-high bit write mask.
- req0_gnt  out  1  access issued to SRAM this cycle.
- req1_vld, req1_wr, req1_addr, req1_wdata, req1_wmask, req1_gnt: same as requester 0.
- rdata_vld  out  1  read data valid.
- rdata_id  out  1  requester that issued the read.
- rdata  out  59  read data.
- init_busy  out  1  init sequence running; all grants blocked.
- sram_cen  out  1  SRAM chip enable, active low.
- sram_gwen  out  1  SRAM global write enable, active low.
- sram_wen  out  59  SRAM bit write enable, active low.
- sram_a  out  9  SRAM address.
- sram_d  out  59  SRAM write data.
- sram_q  in  59  SRAM read data, valid one cycle after a read access.

Behaviour:
- Single clock forever_cpuclk. Reset cpurst_b is asynchronous, active-low.
- Reset values:
  - rr_ptr=0, rd_pend=0, rdata_vld=0, rdata_id=0, rdata hold register=0.
  - gnts=0, sram_cen=1.
  - State = INIT if CT_SPSRAM_ARB_INIT_EN is defined, otherwise RUN.
- Grant (combinational, same cycle as vld, RUN state only):
  - Only one requester valid: it is granted.
  - Both valid: the requester selected by rr_ptr (0 = req0) is granted.
  - rr_ptr update: after any grant to requester i, rr_ptr = ~i. rr_ptr is unchanged when there is no grant.
  - A requester holds vld and its fields stable until granted; no other handshake is required.
- SRAM drive for a granted access (same cycle):
  - sram_cen=0, sram_a=addr.
  - Write: sram_gwen=0, sram_wen=~wmask, sram_d=wdata.
  - Read: sram_gwen=1, sram_wen=all ones.
  - A write with wmask=0 is still issued (CEN low) and leaves memory unchanged.
- SRAM drive with no grant: sram_cen=1, sram_gwen=1, sram_wen=all ones. sram_a and sram_d are don't-care; hold the previous value to save power.
- Read return:
  - Granted read in cycle N: rd_pend=1 and rd_id captured in cycle N+1.
  - In N+1: rdata_vld=1, rdata_id=rd_id, rdata=sram_q, and the hold register captures sram_q.
  - When rd_pend=0: rdata_vld=0 and rdata=hold register, so data stays stable across later writes or idle cycles.
- Back-to-back traffic:
  - Reads may issue every cycle; throughput is one access per cycle.
  - Alternating contention yields strict ping-pong grants.
- Reset mid-operation: an in-flight read is dropped (rdata_vld=0), and a partially completed init restarts from 0.

Optional Feature:
- Macro: CT_SPSRAM_ARB_INIT_EN.
- Defined:
  - FSM INIT -> RUN with a 9-bit init_cnt, reset value 0.
  - In INIT: init_busy=1, both gnts=0; SRAM driven cen=0, gwen=0, wen=all zeros, d=0, a=init_cnt; init_cnt increments each cycle.
  - When init_cnt==INIT_DEPTH-1 the write still occurs, then state goes to RUN next cycle. Total INIT length is exactly 512 cycles.
  - Requests asserted during INIT wait; the first grant can occur in cycle 512 after reset release.
- Undefined: no FSM or counter; init_busy tied 0; block starts in RUN.

Test Plan:
- Without macro: write req0 addr 0x1A5, data 0x5A5A5A5A5A5A5A5, mask all ones; then read req1 addr 0x1A5. Required: gnt same cycle; next cycle rdata_vld=1, rdata_id=1, rdata=0x5A5A5A5A5A5A5A5.
- Partial mask: data all ones at addr 3; then write 0 with mask 0x00000000000000F. Required: sram_wen=0x7FFFFFFFFFFFFF0; read returns 0x7FFFFFFFFFFFFF0.
- Contention: both valid every cycle for 6 cycles from reset. Required grant order req0, req1, req0, req1, req0, req1; never both gnt=1.
- Hold: read addr 3, then 4 idle cycles, then a write to addr 3. Required: rdata_vld pulses once for 1 cycle; rdata stays at the read value through the idle and write cycles.
- With CT_SPSRAM_ARB_INIT_EN: pre-load garbage, reset, hold req0 read addr 511. Required: init_busy=1 for exactly 512 cycles; gnt in cycle 512; rdata=0.
- Reset asserted the cycle after a read grant. Required: rdata_vld=0 asynchronously; rr_ptr=0; no data returned after reset release.
